rvx_local_reg_access_arbiter: RTL and testbench



---
 rtl/rvx_local_reg_access_arbiter.sv | 146 ++++++++++++++
 tb/tb_rvx_local_reg_access_arbiter.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/rvx_local_reg_access_arbiter.sv
// Round-robin arbiter that shares one local register read port among
// NUM_REQ requesters. It holds the reg_req/reg_ack handshake until the
// read completes. A watchdog substitutes ERR_DATA if the register side
// never acks.
module rvx_local_reg_access_arbiter #(
  parameter int          NUM_REQ  = 4,
  parameter int          ADDR_W   = 8,
  parameter int          DATA_W   = 32,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic                      reg_req,
  output logic [ADDR_W-1:0]         reg_addr,
  input  logic                      reg_ack,
  input  logic [DATA_W-1:0]         reg_rdata,
  output logic                      busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int SUM_W = IDX_W + 1;
  // A watchdog-disabled build still needs a 1-bit counter so the RTL elaborates.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam logic [DATA_W-1:0] ERR_D    = DATA_W'(ERR_DATA);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q;
  logic [IDX_W-1:0]   win_q;
  logic [ADDR_W-1:0]  reg_addr_q;
  logic [DATA_W-1:0]  rsp_data_q;
  logic               rsp_err_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               found;
  logic [IDX_W-1:0]   pick;
  logic [SUM_W-1:0]   sum;
  logic [IDX_W-1:0]   cand;
  logic               timeout_hit;

  logic [ADDR_W-1:0]  addr_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
  end

  // Round-robin pick. The search starts at rr_ptr and wraps to 0 after NUM_REQ-1.
  always_comb begin
    found = 1'b0;
    pick  = rr_ptr_q;
    sum   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + SUM_W'(k);
      if (sum >= SUM_W'(NUM_REQ)) sum = sum - SUM_W'(NUM_REQ);
      cand = sum[IDX_W-1:0];
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // The watchdog fires on the last allowed WAIT cycle. An ack in the same cycle takes priority.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and watchdog counter next value
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  if (found) state_d = S_ISSUE;
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        if (reg_ack || timeout_hit) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the current state
  always_comb begin
    reg_req   = (state_q == S_ISSUE) || (state_q == S_WAIT);
    busy      = (state_q != S_IDLE);
    rsp_valid = '0;
    if (state_q == S_RESP) rsp_valid = NUM_REQ'(1) << win_q;
  end

  // Datapath: grant and address latch, response capture, pointer advance, counter
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      win_q      <= '0;
      reg_addr_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            win_q      <= pick;
            reg_addr_q <= addr_arr[pick];
          end
        end
        S_WAIT: begin
          if (reg_ack) begin
            rsp_data_q <= reg_rdata;
            rsp_err_q  <= 1'b0;
          end else if (timeout_hit) begin
            rsp_data_q <= ERR_D;
            rsp_err_q  <= 1'b1;
          end
        end
        S_RESP:  rr_ptr_q <= (win_q == IDX_LAST) ? '0 : win_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign reg_addr = reg_addr_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_rvx_local_reg_access_arbiter.sv
// Directed bench for rvx_local_reg_access_arbiter. Expected responses are
// queued when the register-side ack or timeout is driven. A negedge monitor
// pops them and checks them against every rsp_valid pulse.
module tb_rvx_local_reg_access_arbiter;
  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TO      = 4;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [NUM_REQ-1:0]        req_valid = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr = '0;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_data;
  logic                      rsp_err;
  logic                      reg_req;
  logic [ADDR_W-1:0]         reg_addr;
  logic                      reg_ack = 1'b0;
  logic [DATA_W-1:0]         reg_rdata = '0;
  logic                      busy;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_resp = 0;

  rvx_local_reg_access_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TO),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .reg_req(reg_req), .reg_addr(reg_addr), .reg_ack(reg_ack),
    .reg_rdata(reg_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] addr_of(input int i);
    return 8'h10 + 8'(2 * i);
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (|rsp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 64'(rsp_valid), 64'h0);
      end else begin
        mon_e = q.pop_front();
        chk("rsp_valid", 64'(rsp_valid), 64'(1 << mon_e.idx));
        chk("rsp_data", 64'(rsp_data), 64'(mon_e.data));
        chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
      end
    end
  end

  // Runs one transaction. Called in an IDLE cycle with req_valid already set.
  // ack_at = WAIT cycle carrying reg_ack (0 = never, expect a timeout).
  task automatic txn(input int idx, input int ack_at, input logic [31:0] rdata,
                     input bit drop, input bit keep, input bit chk_period,
                     input bit ack_in_issue);
    int reqcnt;
    reqcnt = 0;
    step();  // ISSUE
    chk("issue_reg_req", 64'(reg_req), 64'h1);
    chk("issue_busy", 64'(busy), 64'h1);
    chk("reg_addr", 64'(reg_addr), 64'(addr_of(idx)));
    if (reg_req) reqcnt++;
    if (ack_in_issue) begin
      reg_ack   = 1'b1;
      reg_rdata = 32'h0BAD_0BAD;
    end
    for (int w = 1; w <= TO + 1; w++) begin
      step();  // WAIT w
      if (reg_req) reqcnt++;
      reg_ack = 1'b0;
      if (drop && w == 1) begin
        req_valid[idx] = 1'b0;
        req_addr[idx*ADDR_W +: ADDR_W] = 8'hEE;
      end
      if (w == ack_at) begin
        reg_ack   = 1'b1;
        reg_rdata = rdata;
        q.push_back('{idx, rdata, 1'b0});
        break;
      end
      if (ack_at == 0 && w == TO) begin
        reg_rdata = 32'h5555_5555;
        q.push_back('{idx, 32'hDEAD_BEEF, 1'b1});
        break;
      end
    end
    step();  // RESP
    reg_ack = 1'b0;
    chk("resp_reg_req", 64'(reg_req), 64'h0);
    chk("resp_valid_now", 64'(rsp_valid), 64'(1 << idx));
    chk("reg_req_cycles", 64'(reqcnt), 64'((ack_at == 0) ? TO + 1 : ack_at + 1));
    if (chk_period) chk("rr_period", 64'(cyc - last_resp), 64'd4);
    last_resp = cyc;
    if (!keep) req_valid[idx] = 1'b0;
    step();  // IDLE
    chk("idle_busy", 64'(busy), 64'h0);
    chk("idle_rsp_valid", 64'(rsp_valid), 64'h0);
    req_addr[idx*ADDR_W +: ADDR_W] = addr_of(idx);
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) req_addr[i*ADDR_W +: ADDR_W] = addr_of(i);

    // Reset state
    step();
    step();
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_reg_req", 64'(reg_req), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_data", 64'(rsp_data), 64'h0);
    chk("rst_rsp_err", 64'(rsp_err), 64'h0);
    chk("rst_reg_addr", 64'(reg_addr), 64'h0);
    rst = 1'b0;

    // Single request on index 2, ack on the first WAIT cycle
    req_valid = 4'b0100;
    txn(2, 1, 32'h0000_00A5, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during WAIT aborts with no response. rr_ptr was 3 before the reset.
    req_valid = 4'b1000;
    step();  // ISSUE
    step();  // WAIT
    chk("midrst_reg_req_pre", 64'(reg_req), 64'h1);
    rst = 1'b1;
    step();
    chk("midrst_reg_req", 64'(reg_req), 64'h0);
    chk("midrst_busy", 64'(busy), 64'h0);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
    rst = 1'b0;

    // All requesters held: grants 0,1,2,3,0, one every 4 cycles
    req_valid = 4'b1111;
    txn(0, 1, 32'hC0DE_0000, 1'b0, 1'b1, 1'b0, 1'b0);
    txn(1, 1, 32'hC0DE_0001, 1'b0, 1'b1, 1'b1, 1'b0);
    txn(2, 1, 32'hC0DE_0002, 1'b0, 1'b1, 1'b1, 1'b0);
    txn(3, 1, 32'hC0DE_0003, 1'b0, 1'b1, 1'b1, 1'b0);
    txn(0, 1, 32'hC0DE_0004, 1'b0, 1'b1, 1'b1, 1'b0);
    req_valid = '0;
    step();
    chk("rr_idle_busy", 64'(busy), 64'h0);

    // Requester 1 withdraws and changes its address in WAIT. The response still goes to 1.
    req_valid = 4'b0010;
    txn(1, 2, 32'h0000_1111, 1'b1, 1'b0, 1'b0, 1'b0);
    // rr_ptr is now 2, so 2 beats 1
    req_valid = 4'b0110;
    txn(2, 1, 32'h0000_2222, 1'b0, 1'b0, 1'b0, 1'b0);
    txn(1, 3, 32'h0000_3333, 1'b0, 1'b0, 1'b0, 1'b0);

    // Watchdog timeout. An ack during ISSUE must be ignored.
    req_valid = 4'b0001;
    txn(0, 0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Ack on the final watchdog cycle wins over the timeout
    req_valid = 4'b1000;
    txn(3, TO, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);

    step();
    step();
    chk("queue_empty", 64'(q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
